// File: rtl/score_mem_ctrl.sv
// score_mem_ctrl: round-robin sequencer for the single-port game score memory.
// Three requesters (0 datapath, 1 FSM, 2 display) share game_mem; each
// transaction revisits IDLE. Optional top-score tracking with autonomous
// write-back is enabled by defining SCORE_TOP_TRACK_EN.
module score_mem_ctrl #(
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int SCORE_ADDR = 0,
  parameter int TOP_ADDR   = 1
) (
  input  logic          iClock,
  input  logic          iResetn,
  input  logic [2:0]    iReq,
  input  logic [2:0]    iWe,
  input  logic [3*AW-1:0] iAddr,
  input  logic [3*DW-1:0] iWdata,
  output logic [2:0]    oAck,
  output logic [DW-1:0] oRdata,
  output logic [AW-1:0] oMemAddr,
  output logic [DW-1:0] oMemData,
  output logic          oMemWren,
  input  logic [DW-1:0] iMemQ,
  output logic [DW-1:0] oTopScore,
  output logic          oBusy
);

`ifdef SCORE_TOP_TRACK_EN
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, TOPWR} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE} state_t;
`endif

  state_t     state, nxt;
  logic [1:0] last;     // most recently served requester
  logic [1:0] gnt;      // requester owning the current transaction
  logic [1:0] pick;     // round-robin winner among current requests
  logic       found;
  logic       we_q;
`ifdef SCORE_TOP_TRACK_EN
  logic       pend;     // top score changed, write-back owed
  logic [DW-1:0] top_q;
  assign oTopScore = top_q;
`else
  assign oTopScore = '0;
`endif

  // Round-robin search: last+1, last+2, then last itself.
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= 3; i++) begin
      logic [1:0] cand;
      cand = 2'((int'(last) + i) % 3);
      if (!found && iReq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state logic; a pending top-score write-back beats external requests.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
`ifdef SCORE_TOP_TRACK_EN
        if (pend) nxt = TOPWR;
        else
`endif
        if (found) nxt = ACCESS;
      end
      ACCESS:  nxt = we_q ? DONE : WAIT;
      WAIT:    nxt = DONE;
      DONE:    nxt = IDLE;
`ifdef SCORE_TOP_TRACK_EN
      TOPWR:   nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  // State, latched payload and registered memory/handshake outputs.
  // Memory address/data registers double as the latched request payload.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state    <= IDLE;
      last     <= 2'd2;
      gnt      <= 2'd0;
      we_q     <= 1'b0;
      oAck     <= '0;
      oRdata   <= '0;
      oMemAddr <= '0;
      oMemData <= '0;
      oMemWren <= 1'b0;
      oBusy    <= 1'b0;
`ifdef SCORE_TOP_TRACK_EN
      pend     <= 1'b0;
      top_q    <= '0;
`endif
    end else begin
      state <= nxt;
      oBusy <= (nxt != IDLE);
      oAck  <= '0;
      case (state)
        IDLE: begin
          if (nxt == ACCESS) begin
            gnt      <= pick;
            we_q     <= iWe[pick];
            oMemAddr <= iAddr[pick*AW +: AW];
            oMemData <= iWdata[pick*DW +: DW];
            oMemWren <= iWe[pick];
          end
`ifdef SCORE_TOP_TRACK_EN
          if (nxt == TOPWR) begin
            oMemAddr <= AW'(TOP_ADDR);
            oMemData <= top_q;
            oMemWren <= 1'b1;
          end
`endif
        end
        ACCESS: begin
          oMemWren <= 1'b0;
          if (we_q) oAck[gnt] <= 1'b1;
        end
        WAIT: begin
          oRdata    <= iMemQ;
          oAck[gnt] <= 1'b1;
        end
        DONE: begin
          last <= gnt;
`ifdef SCORE_TOP_TRACK_EN
          if (we_q && oMemAddr == AW'(SCORE_ADDR) && oMemData > top_q) begin
            top_q <= oMemData;
            pend  <= 1'b1;
          end
`endif
        end
`ifdef SCORE_TOP_TRACK_EN
        TOPWR: begin
          oMemWren <= 1'b0;
          pend     <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
